// File: rtl/calc_arith_sseg.sv
// Arithmetic/display core of the 8-bit calculator: combinational adder, registered 8x8 multiplier,
// 4-digit multiplexed 7-segment driver. sum: 0 cycles; product, an, seg: 1 cycle. No backpressure.
// Optional LEADING_ZERO_BLANK_EN: blanks leading zero digits, rightmost digit always shown.
module calc_arith_sseg #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic [15:0] sum,
  output logic [15:0] product,
  input  logic [15:0] disp_data,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [15:0]             product_q, product_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    lead_zero;

  // Active-low {g,f,e,d,c,b,a} pattern for a full hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  // Adder: 9-bit result zero-extended, carry lands in bit 8.
  always_comb begin
    sum = {7'b0, ({1'b0, op_a} + {1'b0, op_b})};
  end

  // Top two scan-counter bits choose the digit currently driven.
  always_comb begin
    sel   = cnt_q[REFRESH_BITS-1 -: 2];
    digit = 4'h0;
    case (sel)
      2'd0: digit = disp_data[3:0];
      2'd1: digit = disp_data[7:4];
      2'd2: digit = disp_data[11:8];
      default: digit = disp_data[15:12];
    endcase
  end

  // A digit counts as a leading zero when it and every more-significant code are zero.
  always_comb begin
    lead_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (sel)
      2'd1: lead_zero = (disp_data[15:4] == 12'h000);
      2'd2: lead_zero = (disp_data[15:8] == 8'h00);
      2'd3: lead_zero = (disp_data[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
`endif
  end

  // Next-state: free-running counter, product, and anode/segment pattern.
  always_comb begin
    cnt_d     = cnt_q + REFRESH_BITS'(1);
    product_d = {8'b0, op_a} * {8'b0, op_b};
    an_d      = 4'b1111;
    seg_d     = 7'h7F;
    if (!blank && !lead_zero) begin
      an_d  = ~(4'b0001 << sel);
      seg_d = hex_to_seg(digit);
    end
  end

  // State register; reset wins over blank and everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      product_q <= 16'h0000;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
    end else begin
      cnt_q     <= cnt_d;
      product_q <= product_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  // Decimal point is never used by this display.
  always_comb begin
    product = product_q;
    an      = an_q;
    seg     = seg_q;
    dp      = 1'b1;
  end

endmodule

// File: tb/tb_calc_arith_sseg.sv
// Randomized and directed bench for calc_arith_sseg with a fast scan counter (REFRESH_BITS=4).
// Outputs are sampled on the falling edge against a cycle-level reference model.
// Builds with or without LEADING_ZERO_BLANK_EN; the model follows the same macro.
module tb_calc_arith_sseg;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  op_a, op_b;
  logic [15:0] sum, product, disp_data;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs must show after the next rising edge.
  int          m_cnt;
  logic [15:0] m_prod;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [6:0]  seg_tab [16];

  calc_arith_sseg #(.REFRESH_BITS(4)) dut (
    .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b), .sum(sum), .product(product),
    .disp_data(disp_data), .blank(blank), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference: 4 clocks per digit, digit order right to left.
  task automatic model_edge();
    int  sel;
    int  upper;
    bit  lz;
    if (reset) begin
      m_cnt = 0; m_prod = 16'h0; m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      sel   = m_cnt / 4;
      upper = int'(disp_data) >> (4 * sel);
      lz    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lz    = (sel > 0) && (upper == 0);
`endif
      if (blank || lz) begin
        m_an = 4'hF; m_seg = 7'h7F;
      end else begin
        m_an  = 4'(15 - (1 << sel));
        m_seg = seg_tab[upper % 16];
      end
      m_prod = 16'(int'(op_a) * int'(op_b));
      m_cnt  = (m_cnt + 1) % 16;
    end
  endtask

  // Called at a falling edge: apply inputs, check sum, advance model, check registered outputs.
  task automatic cycle(input logic r, input logic bl, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] d);
    reset = r; blank = bl; op_a = a; op_b = b; disp_data = d;
    #1;
    check("sum", sum, 16'(int'(a) + int'(b)));
    model_edge();
    @(negedge clk);
    check("product", product, m_prod);
    check("an", {12'h0, an}, {12'h0, m_an});
    check("seg", {9'h0, seg}, {9'h0, m_seg});
    check("dp", {15'h0, dp}, 16'h1);
  endtask

  function automatic logic [15:0] rand_disp();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  logic [7:0] dir_a [4];
  logic [7:0] dir_b [4];

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    dir_a = '{8'hFF, 8'd200, 8'd255, 8'd12};
    dir_b = '{8'h01, 8'd100, 8'd255, 8'd0};
    reset = 1'b1; blank = 1'b0; op_a = 8'h0; op_b = 8'h0; disp_data = 16'h0;
    m_cnt = 0; m_prod = 16'h0; m_an = 4'hF; m_seg = 7'h7F;
    @(negedge clk);

    // Reset, then scan 0x1234 with the directed arithmetic corner cases.
    cycle(1'b1, 1'b0, 8'h0, 8'h0, 16'h1234);
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_seg", {9'h0, seg}, 16'h007F);
    check("rst_prod", product, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, dir_a[i % 4], dir_b[i % 4], 16'h1234);
      if (i % 4 == 2) check("prod_fe01", product, 16'hFE01);
    end

    // Blank mid-scan, release, then reset while blanked.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'd3, 8'd5, 16'h1234);
    check("blank_an", {12'h0, an}, 16'h000F);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'd3, 8'd5, 16'h1234);
    cycle(1'b1, 1'b1, 8'd9, 8'd9, 16'h1234);
    check("rst_blank_prod", product, 16'h0000);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom), 16'hABCD);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom), 16'h0042);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom), 16'h0007);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom), 16'h0000);

    // Random traffic with occasional blank and reset, display value held for a few clocks.
    begin
      logic [15:0] d;
      d = rand_disp();
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 7) == 0) d = rand_disp();
        cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0),
              8'($urandom), 8'($urandom), d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
